dc_fifo_wr_arb: RTL and testbench
=================================

# dc_fifo_wr_arb

Packet-atomic round-robin arbiter that shares the write port of one dual-clock FIFO among NUM_CH streaming requesters in the write clock domain. It sits in front of the shared FIFO in the 8-channel datapath. It holds a grant from SOP to EOP, so packets are never interleaved in the FIFO. It never issues a write while the FIFO reports full, because the FIFO is built with overflow checking off.

## Interface
Parameters:
- NUM_CH, 8, number of requesting channels (2..16).
- DATA_WIDTH, 64, payload width per beat.
- CH_W, derived as max(1, $clog2(NUM_CH)); not overridable.
- FIFO_W, derived as DATA_WIDTH+2, or DATA_WIDTH+2+CH_W when the channel tag is compiled in.

Ports:
- wrclk  in  1  FIFO write-side clock; the only clock of the block.
- wr_rst_n  in  1  reset, asynchronous assert, active-low.
- ch_valid  in  NUM_CH  per-channel beat valid.
- ch_ready  out  NUM_CH  per-channel beat accept.
- ch_data  in  NUM_CH*DATA_WIDTH  per-channel payload; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ch_sop  in  NUM_CH  first beat of packet.
- ch_eop  in  NUM_CH  last beat of packet.
- fifo_wrreq  out  1  FIFO write strobe.
- fifo_data  out  FIFO_W  FIFO write word.
- fifo_wrfull  in  1  FIFO full flag, write domain.
- grant_oh  out  NUM_CH  one-hot current grant; 0 when idle.
- busy  out  1  a packet is in flight.
- proto_err  out  1  sticky SOP/EOP framing violation flag.

## Operation
State machine with states IDLE and BUSY.

- **IDLE**
  - If any ch_valid is high, select the first valid channel searching upward from last_ch+1, wrapping modulo NUM_CH.
  - Register that channel into grant_oh, go to BUSY, and set last_ch to the selected channel.
  - ch_ready stays all-zero in IDLE.
- **BUSY**
  - ch_ready[g] = !fifo_wrfull for the granted channel g; all other ready bits are 0.
  - A beat is accepted when ch_valid[g] && ch_ready[g].
  - An accepted beat with ch_eop[g] returns the FSM to IDLE and clears grant_oh.
  - A single-beat packet (sop and eop both set) is legal.
- **Write path (combinational from the registered grant)**
  - fifo_wrreq = accepted beat.
  - fifo_data = {ch_eop[g], ch_sop[g], ch_data[g]}, with the tag added when the macro is compiled in.
  - When fifo_wrreq is low, fifo_data is don't-care.
- **Framing check**
  - proto_err is set when the first accepted beat of a grant has sop=0.
  - proto_err is also set when a later beat of the same grant has sop=1.
  - The offending beat is still written and grant handling is unchanged.
  - proto_err clears only on reset.
- **Fairness**
  - last_ch resets to NUM_CH-1, so channel 0 wins the first arbitration.
  - A channel cannot win twice in a row while any other channel is valid.

## Timing
- Reset values: the state is IDLE, grant_oh = 0, ch_ready = 0, fifo_wrreq = 0, busy = 0, proto_err = 0, and last_ch = NUM_CH-1.
- Arbitration takes 1 cycle. A request seen in IDLE on cycle t gives grant_oh and ch_ready on cycle t+1.
- Packets are separated by one idle cycle. Sustained throughput is N beats per N+1 cycles for N-beat packets.
- Beat-to-FIFO latency is 0 cycles, since fifo_wrreq is combinational.
- ch_ready depends combinationally on fifo_wrfull and the registered grant only, never on ch_valid.
- When fifo_wrfull is high, no write occurs; the grant is held and data is held by the source.
- When ch_valid[g] drops mid-packet, the grant is held indefinitely and no timeout applies.
- Reset asserted mid-packet clears all state immediately. The partial packet in the FIFO is the downstream block's concern.
- Simultaneous eop-accept and new requests: the IDLE cycle follows first, then arbitration uses the updated last_ch.

## Configuration
- DC_FIFO_WR_ARB_CH_TAG_EN defined:
  - FIFO_W = DATA_WIDTH+2+CH_W.
  - fifo_data = {g[CH_W-1:0], eop, sop, data}, which lets the read side demultiplex by channel.
- Not defined:
  - FIFO_W = DATA_WIDTH+2 and no channel index is stored.
  - All other behaviour is identical.

## Test plan
- **Single packet:** channel 3 sends a 3-beat packet 0xA1/0xA2/0xA3 with fifo_wrfull=0 -> grant_oh=0x08 one cycle after valid; 3 consecutive fifo_wrreq with sop on the first beat and eop on the last; then IDLE, grant_oh=0.
- **Round robin:** channels 0, 1 and 5 each hold valid with 2-beat packets continuously from reset -> grant order 0, 1, 5, 0; exactly one idle cycle between packets.
- **Backpressure:** fifo_wrfull=1 for cycles 2-4 of a 4-beat packet -> ch_ready=0 and fifo_wrreq=0 for those cycles; grant held; all 4 beats written in order with none duplicated.
- **Framing error:** first beat of a grant has sop=0, or a mid-packet beat has sop=1 -> proto_err=1 from the next cycle and stays set; the beat is still written.
- **Reset mid-packet:** wr_rst_n pulsed low after 2 of 5 beats -> all outputs at reset values asynchronously; the next arbitration grants the lowest-index valid channel.
- **Channel tag:** with DC_FIFO_WR_ARB_CH_TAG_EN, a channel 6 beat -> fifo_data top CH_W bits = 6; without the macro, fifo_data width = DATA_WIDTH+2.

Source files
------------

// File: rtl/dc_fifo_wr_arb.sv
// rtl/dc_fifo_wr_arb.sv - packet-atomic round-robin arbiter for the write port of a shared dual-clock FIFO
// Define DC_FIFO_WR_ARB_CH_TAG_EN to prepend the granted channel index to every FIFO word.
module dc_fifo_wr_arb #(
  parameter int NUM_CH     = 8,
  parameter int DATA_WIDTH = 64,
  localparam int CH_W      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
`ifdef DC_FIFO_WR_ARB_CH_TAG_EN
  localparam int FIFO_W    = DATA_WIDTH + 2 + CH_W
`else
  localparam int FIFO_W    = DATA_WIDTH + 2
`endif
) (
  input  logic                         wrclk,
  input  logic                         wr_rst_n,
  input  logic [NUM_CH-1:0]            ch_valid,
  output logic [NUM_CH-1:0]            ch_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_sop,
  input  logic [NUM_CH-1:0]            ch_eop,
  output logic                         fifo_wrreq,
  output logic [FIFO_W-1:0]            fifo_data,
  input  logic                         fifo_wrfull,
  output logic [NUM_CH-1:0]            grant_oh,
  output logic                         busy,
  output logic                         proto_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_n;
  logic [CH_W-1:0]       grant_idx, grant_idx_n;
  logic [CH_W-1:0]       last_ch, last_ch_n;
  logic [CH_W-1:0]       cand;
  logic [NUM_CH-1:0]     grant_oh_n;
  logic                  first_beat, first_beat_n;
  logic                  proto_err_n;
  logic                  accept;
  logic                  found;
  logic                  g_sop, g_eop;
  logic [DATA_WIDTH-1:0] g_data;

  always_ff @(posedge wrclk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state      <= IDLE;
      grant_idx  <= '0;
      grant_oh   <= '0;
      last_ch    <= CH_W'(NUM_CH - 1);
      first_beat <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_n;
      grant_idx  <= grant_idx_n;
      grant_oh   <= grant_oh_n;
      last_ch    <= last_ch_n;
      first_beat <= first_beat_n;
      proto_err  <= proto_err_n;
    end
  end

  // The write path is steered only by the registered grant index.
  assign g_sop  = ch_sop[grant_idx];
  assign g_eop  = ch_eop[grant_idx];
  assign g_data = ch_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_n      = state;
    grant_idx_n  = grant_idx;
    grant_oh_n   = grant_oh;
    last_ch_n    = last_ch;
    first_beat_n = first_beat;
    proto_err_n  = proto_err;
    ch_ready     = '0;
    accept       = 1'b0;
    found        = 1'b0;
    cand         = '0;
    busy         = (state == BUSY);

    case (state)
      IDLE: begin
        // Search upward from the channel after the previous winner, wrapping.
        for (int k = 1; k <= NUM_CH; k++) begin
          cand = CH_W'((int'(last_ch) + k) % NUM_CH);
          if (!found && ch_valid[cand]) begin
            found       = 1'b1;
            grant_idx_n = cand;
          end
        end
        if (found) begin
          state_n      = BUSY;
          grant_oh_n   = NUM_CH'(1) << grant_idx_n;
          last_ch_n    = grant_idx_n;
          first_beat_n = 1'b1;
        end
      end
      BUSY: begin
        ch_ready = fifo_wrfull ? '0 : grant_oh;
        accept   = ch_valid[grant_idx] && !fifo_wrfull;
        if (accept) begin
          // sop must be set on exactly the first accepted beat of a grant.
          if (first_beat != g_sop) begin
            proto_err_n = 1'b1;
          end
          first_beat_n = 1'b0;
          if (g_eop) begin
            state_n    = IDLE;
            grant_oh_n = '0;
          end
        end
      end
    endcase
  end

  assign fifo_wrreq = accept;

`ifdef DC_FIFO_WR_ARB_CH_TAG_EN
  assign fifo_data = {grant_idx, g_eop, g_sop, g_data};
`else
  assign fifo_data = {g_eop, g_sop, g_data};
`endif

endmodule

// File: tb/tb_dc_fifo_wr_arb.sv
// tb/tb_dc_fifo_wr_arb.sv - self-checking bench for dc_fifo_wr_arb with behavioural model and randomized sources
module tb_dc_fifo_wr_arb;
  localparam int NUM_CH = 8;
  localparam int DW     = 64;
  localparam int CH_W   = 3;
`ifdef DC_FIFO_WR_ARB_CH_TAG_EN
  localparam int FIFO_W = DW + 2 + CH_W;
`else
  localparam int FIFO_W = DW + 2;
`endif

  logic                   wrclk = 1'b0;
  logic                   wr_rst_n = 1'b0;
  logic [NUM_CH-1:0]      ch_valid = '0;
  logic [NUM_CH-1:0]      ch_ready;
  logic [NUM_CH*DW-1:0]   ch_data = '0;
  logic [NUM_CH-1:0]      ch_sop = '0;
  logic [NUM_CH-1:0]      ch_eop = '0;
  logic                   fifo_wrreq;
  logic [FIFO_W-1:0]      fifo_data;
  logic                   fifo_wrfull = 1'b0;
  logic [NUM_CH-1:0]      grant_oh;
  logic                   busy;
  logic                   proto_err;

  int total = 0;
  int bad   = 0;

  always #5 wrclk = ~wrclk;

  dc_fifo_wr_arb #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) dut (
    .wrclk      (wrclk),
    .wr_rst_n   (wr_rst_n),
    .ch_valid   (ch_valid),
    .ch_ready   (ch_ready),
    .ch_data    (ch_data),
    .ch_sop     (ch_sop),
    .ch_eop     (ch_eop),
    .fifo_wrreq (fifo_wrreq),
    .fifo_data  (fifo_data),
    .fifo_wrfull(fifo_wrfull),
    .grant_oh   (grant_oh),
    .busy       (busy),
    .proto_err  (proto_err)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic chkw(string n, logic [FIFO_W-1:0] act, logic [FIFO_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [FIFO_W-1:0] mkw(int c, logic e, logic s, logic [DW-1:0] d);
`ifdef DC_FIFO_WR_ARB_CH_TAG_EN
    return {CH_W'(c), e, s, d};
`else
    return {e, s, d};
`endif
  endfunction

  // Behavioural model: arbitration state in plain integers.
  bit              m_busy, m_first, m_perr;
  int              m_g, m_last;
  logic [31:0]     exp_grant;
  logic            exp_wr;
  logic [NUM_CH-1:0] prev_grant;
  logic [DW+1:0]   sb_word;
  int              n_writes = 0;
  int              grant_log[$];
  int              dut_grants[$];
  bit              sb_en = 1'b0;
  logic [DW+1:0]   expq[NUM_CH][$];

  always @(negedge wrclk) begin
    if (!wr_rst_n) begin
      chk("rst_grant_oh", 32'(grant_oh), 32'h0);
      chk("rst_ch_ready", 32'(ch_ready), 32'h0);
      chk("rst_fifo_wrreq", 32'(fifo_wrreq), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_proto_err", 32'(proto_err), 32'h0);
      m_busy = 0; m_first = 0; m_perr = 0; m_g = 0; m_last = NUM_CH - 1;
      prev_grant = '0;
    end else begin
      exp_grant = m_busy ? (32'd1 << m_g) : 32'd0;
      exp_wr    = m_busy && !fifo_wrfull && ch_valid[m_g];
      chk("grant_oh", 32'(grant_oh), exp_grant);
      chk("ch_ready", 32'(ch_ready), fifo_wrfull ? 32'd0 : exp_grant);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("proto_err", 32'(proto_err), 32'(m_perr));
      chk("fifo_wrreq", 32'(fifo_wrreq), 32'(exp_wr));
      if (grant_oh != '0 && prev_grant == '0)
        for (int k = 0; k < NUM_CH; k++) if (grant_oh[k]) dut_grants.push_back(k);
      prev_grant = grant_oh;
      if (exp_wr) begin
        chkw("fifo_data", fifo_data, mkw(m_g, ch_eop[m_g], ch_sop[m_g], ch_data[m_g*DW +: DW]));
        if (sb_en) begin
          if (expq[m_g].size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: got write on ch%0d want none pending", m_g);
          end else begin
            sb_word = expq[m_g].pop_front();
            chkw("sb_beat", fifo_data, mkw(m_g, sb_word[DW+1], sb_word[DW], sb_word[DW-1:0]));
          end
        end
        n_writes++;
        if (m_first ? !ch_sop[m_g] : ch_sop[m_g]) m_perr = 1;
        m_first = 0;
        if (ch_eop[m_g]) m_busy = 0;
      end else if (!m_busy && ch_valid != '0) begin
        for (int k = 1; k <= NUM_CH; k++) begin
          if (ch_valid[(m_last + k) % NUM_CH]) begin
            m_g = (m_last + k) % NUM_CH;
            break;
          end
        end
        m_busy = 1; m_last = m_g; m_first = 1;
        grant_log.push_back(m_g);
      end
    end
  end

  // Randomized packet sources
  int rem[NUM_CH];
  bit holding[NUM_CH];
  int seq[NUM_CH];

  task automatic step();
    @(posedge wrclk);
    #1;
  endtask

  task automatic set_ch(int c, bit v, bit s, bit e, logic [DW-1:0] d);
    ch_valid[c] = v; ch_sop[c] = s; ch_eop[c] = e; ch_data[c*DW +: DW] = d;
  endtask

  task automatic clear_in();
    ch_valid = '0; ch_sop = '0; ch_eop = '0; ch_data = '0; fifo_wrfull = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge wrclk);
    #2 wr_rst_n = 1'b0;
    #1;
    chk("arst_grant_oh", 32'(grant_oh), 32'h0);
    chk("arst_ch_ready", 32'(ch_ready), 32'h0);
    chk("arst_wrreq", 32'(fifo_wrreq), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_proto_err", 32'(proto_err), 32'h0);
    clear_in();
    sb_en = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      rem[i] = 0; holding[i] = 0; expq[i].delete();
    end
    grant_log.delete();
    dut_grants.delete();
    @(posedge wrclk);
    @(posedge wrclk);
    #3 wr_rst_n = 1'b1;
  endtask

  task automatic run_engine(int cycles, logic [NUM_CH-1:0] mask, int pv, int lmin, int lmax, int pfull);
    logic [NUM_CH-1:0] acc;
    bit s, e;
    logic [DW-1:0] d;
    sb_en = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge wrclk);
      acc = ch_valid & ch_ready;
      @(posedge wrclk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (acc[i]) begin
          holding[i] = 0;
          rem[i]--;
        end
        if (!holding[i] && mask[i] && $urandom_range(99) < pv) begin
          s = (rem[i] == 0);
          if (s) rem[i] = $urandom_range(lmax, lmin);
          e = (rem[i] == 1);
          d = {8'(i), 24'(seq[i]), 32'($urandom)};
          seq[i]++;
          set_ch(i, 1'b1, s, e, d);
          expq[i].push_back({e, s, d});
          holding[i] = 1;
        end
        ch_valid[i] = holding[i];
      end
      fifo_wrfull = ($urandom_range(99) < pfull);
    end
  endtask

  int rr_exp[4] = '{0, 1, 5, 0};
  int wr_before;

  initial begin
    do_reset();

    // Single 3-beat packet on channel 3
    step(); set_ch(3, 1, 1, 0, 64'hA1); #1;
    chk("sp_idle_grant", 32'(grant_oh), 32'h0);
    chk("sp_idle_ready", 32'(ch_ready), 32'h0);
    step(); #1;
    chk("sp_grant", 32'(grant_oh), 32'h8);
    chk("sp_ready", 32'(ch_ready), 32'h8);
    chk("sp_wr1", 32'(fifo_wrreq), 32'h1);
    chkw("sp_data1", fifo_data, mkw(3, 1'b0, 1'b1, 64'hA1));
    step(); set_ch(3, 1, 0, 0, 64'hA2); #1;
    chkw("sp_data2", fifo_data, mkw(3, 1'b0, 1'b0, 64'hA2));
    step(); set_ch(3, 1, 0, 1, 64'hA3); #1;
    chkw("sp_data3", fifo_data, mkw(3, 1'b1, 1'b0, 64'hA3));
    step(); set_ch(3, 0, 0, 0, 64'h0); #1;
    chk("sp_end_grant", 32'(grant_oh), 32'h0);
    chk("sp_end_busy", 32'(busy), 32'h0);

    // Round robin among channels 0, 1, 5 with continuous 2-beat packets
    do_reset();
    run_engine(14, 8'b0010_0011, 100, 2, 2, 0);
    sb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_dut_%0d", i), (i < dut_grants.size()) ? dut_grants[i] : -1, rr_exp[i]);
      chk($sformatf("rr_model_%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, rr_exp[i]);
    end

    // Backpressure for three cycles inside a 4-beat packet on channel 2
    do_reset();
    wr_before = n_writes;
    step(); set_ch(2, 1, 1, 0, 64'hB0);
    step(); #1;
    chkw("bp_data0", fifo_data, mkw(2, 1'b0, 1'b1, 64'hB0));
    step(); set_ch(2, 1, 0, 0, 64'hB1); fifo_wrfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      chk("bp_full_ready", 32'(ch_ready), 32'h0);
      chk("bp_full_wrreq", 32'(fifo_wrreq), 32'h0);
      chk("bp_full_grant", 32'(grant_oh), 32'h4);
    end
    step(); fifo_wrfull = 1'b0; #1;
    chkw("bp_data1", fifo_data, mkw(2, 1'b0, 1'b0, 64'hB1));
    step(); set_ch(2, 1, 0, 0, 64'hB2); #1;
    chkw("bp_data2", fifo_data, mkw(2, 1'b0, 1'b0, 64'hB2));
    step(); set_ch(2, 1, 0, 1, 64'hB3); #1;
    chkw("bp_data3", fifo_data, mkw(2, 1'b1, 1'b0, 64'hB3));
    step(); clear_in(); #1;
    chk("bp_writes", n_writes - wr_before, 4);

    // Framing error: first beat without sop
    do_reset();
    step(); set_ch(4, 1, 0, 1, 64'hC0);
    step(); #1;
    chk("fe_first_wr", 32'(fifo_wrreq), 32'h1);
    chk("fe_first_pre", 32'(proto_err), 32'h0);
    step(); set_ch(4, 0, 0, 0, 64'h0); #1;
    chk("fe_first_err", 32'(proto_err), 32'h1);
    step(); set_ch(4, 1, 1, 1, 64'hC1);
    step(); step(); clear_in(); #1;
    chk("fe_sticky", 32'(proto_err), 32'h1);

    // Framing error: sop repeated mid-packet
    do_reset();
    step(); set_ch(2, 1, 1, 0, 64'hD0);
    step();
    step(); set_ch(2, 1, 1, 1, 64'hD1); #1;
    chk("fe_mid_wr", 32'(fifo_wrreq), 32'h1);
    chk("fe_mid_pre", 32'(proto_err), 32'h0);
    step(); clear_in(); #1;
    chk("fe_mid_err", 32'(proto_err), 32'h1);

    // Asynchronous reset after 2 of 5 beats
    do_reset();
    step(); set_ch(1, 1, 1, 0, 64'hE0);
    step();
    step(); set_ch(1, 1, 0, 0, 64'hE1);
    step(); set_ch(1, 1, 0, 0, 64'hE2); #2;
    wr_rst_n = 1'b0; #1;
    chk("rm_grant", 32'(grant_oh), 32'h0);
    chk("rm_ready", 32'(ch_ready), 32'h0);
    chk("rm_wrreq", 32'(fifo_wrreq), 32'h0);
    chk("rm_busy", 32'(busy), 32'h0);
    clear_in();
    set_ch(5, 1, 1, 1, 64'hE5);
    set_ch(3, 1, 1, 1, 64'hE3);
    @(posedge wrclk);
    #3 wr_rst_n = 1'b1;
    step(); #1;
    chk("rm_regrant", 32'(grant_oh), 32'h8);
    step(); clear_in();

    // Channel 6 beat: tag or bare word format
    do_reset();
    step(); set_ch(6, 1, 1, 1, 64'h66);
    step(); #1;
    chk("tag_wr", 32'(fifo_wrreq), 32'h1);
`ifdef DC_FIFO_WR_ARB_CH_TAG_EN
    chk("tag_value", 32'(fifo_data[FIFO_W-1 -: CH_W]), 32'h6);
`else
    chkw("tag_none", fifo_data, {1'b1, 1'b1, 64'h66});
`endif
    step(); clear_in();

    // Randomized traffic with backpressure, then saturated traffic
    do_reset();
    run_engine(3000, 8'hFF, 60, 1, 4, 25);
    run_engine(1000, 8'hFF, 100, 1, 3, 0);
    sb_en = 1'b0;
    chk("rand_progress", 32'(n_writes > 1000), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
